// File: rtl/jam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jam_pkg
//  Description : Shared types and helpers for the jam_solver job-assignment
//                engine: FSM state encoding, optimisation mode constants and
//                width helpers for the worker index and cost-sum buses.
//  Revision    : 1.0 - initial release
// ============================================================================
package jam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CAL  = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Width of a worker/job index for n workers.
    function automatic int iw_f(input int n);
        return $clog2(n);
    endfunction

    // Width of a total over n costs of cw bits; cannot overflow.
    function automatic int sw_f(input int n, input int cw);
        return cw + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jam_next_perm.sv
`default_nettype none
// ============================================================================
//  Module      : jam_next_perm
//  Description : Combinational next-lexicographic-permutation generator.
//                i_perm[IW*k +: IW] holds element k. o_is_last is high when
//                i_perm is fully descending (N-1,...,0); o_next is then
//                meaningless.
//  Ports       : i_perm    - current permutation
//                o_next    - next permutation in lexicographic order
//                o_is_last - current permutation is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module jam_next_perm import jam_pkg::*; #(
    parameter int N = 8
) (
    input  logic [N*iw_f(N)-1:0] i_perm,
    output logic [N*iw_f(N)-1:0] o_next,
    output logic                 o_is_last
);
    localparam int IW = iw_f(N);

    logic [IW-1:0] w_p [N];
    logic [IW-1:0] w_q [N];
    int            w_pivot;
    int            w_succ;
    logic          w_found;
    logic          w_sfound;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_p[k] = i_perm[IW*k +: IW];
        end

        // Pivot: rightmost position followed by a larger element.
        w_pivot = 0;
        w_found = 1'b0;
        for (int i = N-2; i >= 0; i--) begin
            if (!w_found && (w_p[i] < w_p[i+1])) begin
                w_pivot = i;
                w_found = 1'b1;
            end
        end

        // The suffix after the pivot is descending, so the rightmost element
        // larger than the pivot is also the smallest such element.
        w_succ   = N-1;
        w_sfound = 1'b0;
        for (int j = N-1; j >= 1; j--) begin
            if (!w_sfound && (j > w_pivot) && (w_p[j] > w_p[w_pivot])) begin
                w_succ   = j;
                w_sfound = 1'b1;
            end
        end

        for (int k = 0; k < N; k++) begin
            w_q[k] = w_p[k];
        end
        w_q[w_pivot] = w_p[w_succ];
        w_q[w_succ]  = w_p[w_pivot];

        // Reverse the suffix to make it ascending.
        o_next = '0;
        for (int k = 0; k < N; k++) begin
            if (k <= w_pivot) begin
                o_next[IW*k +: IW] = w_q[k];
            end else begin
                o_next[IW*k +: IW] = w_q[N + w_pivot - k];
            end
        end

        o_is_last = !w_found;
    end

endmodule
`default_nettype wire

// File: rtl/jam_solver.sv
`default_nettype none
// ============================================================================
//  Module      : jam_solver
//  Description : Exhaustive job-assignment solver. Walks all N! worker->job
//                permutations in lexicographic order, one cost per cycle from
//                an external combinational cost ROM, and reports the optimum
//                total (min or max), the number of optimal permutations
//                (saturating) and the lexicographically first optimum.
//  Ports       : CLK, RST        - clock, synchronous active-high reset
//                Start, Mode     - run request, 0=minimise 1=maximise
//                W, J, Cost      - cost ROM address (worker, job) and data
//                Busy, Valid     - run in progress / results valid
//                MinCost, MatchCount, BestPerm - results
//  Revision    : 1.0 - initial release
// ============================================================================
module jam_solver import jam_pkg::*; #(
    parameter int N   = 8,
    parameter int CW  = 7,
    parameter int MCW = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Start,
    input  logic                   Mode,
    output logic [iw_f(N)-1:0]     W,
    output logic [iw_f(N)-1:0]     J,
    input  logic [CW-1:0]          Cost,
    output logic                   Busy,
    output logic                   Valid,
    output logic [sw_f(N,CW)-1:0]  MinCost,
    output logic [MCW-1:0]         MatchCount,
    output logic [N*iw_f(N)-1:0]   BestPerm
);
    localparam int            IW     = iw_f(N);
    localparam int            SW     = sw_f(N, CW);
    localparam logic [IW-1:0] W_LAST = IW'(N-1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            r_valid;
    logic [N*IW-1:0] r_perm;
    logic [N*IW-1:0] w_ident;
    logic [N*IW-1:0] w_next_perm;
    logic            w_is_last;
    logic [IW-1:0]   r_w;
    logic [SW-1:0]   r_acc;
    logic [SW-1:0]   w_total;
    logic            r_first;
    logic            r_mode;
    logic [SW-1:0]   r_min;
    logic [MCW-1:0]  r_cnt;
    logic [N*IW-1:0] r_best;
    logic            w_start_ok;
    logic            w_better;

    generate
        for (genvar g = 0; g < N; g++) begin : g_ident
            assign w_ident[IW*g +: IW] = IW'(g);
        end
    endgenerate

    jam_next_perm #(.N(N)) u_next_perm (
        .i_perm    (r_perm),
        .o_next    (w_next_perm),
        .o_is_last (w_is_last)
    );

    assign w_start_ok = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_total    = r_acc + SW'(Cost);
    assign w_better   = (r_mode == MODE_MAX) ? (w_total > r_min) : (w_total < r_min);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CAL) ||
                       (w_state_nxt == ST_NEXT);
            r_valid <= (w_state_nxt == ST_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (Start) w_state_nxt = ST_LOAD;
            ST_LOAD:          w_state_nxt = ST_CAL;
            ST_CAL: begin
                if (r_w == W_LAST) begin
                    w_state_nxt = w_is_last ? ST_DONE : ST_NEXT;
                end
            end
            ST_NEXT:          w_state_nxt = ST_CAL;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_perm  <= w_ident;
            r_w     <= '0;
            r_acc   <= '0;
            r_first <= 1'b1;
            r_mode  <= MODE_MIN;
            r_min   <= '1;
            r_cnt   <= '0;
            r_best  <= w_ident;
        end else begin
            if (w_start_ok) begin
                r_mode <= Mode;
            end
            case (r_state)
                ST_LOAD: begin
                    r_perm  <= w_ident;
                    r_w     <= '0;
                    r_acc   <= '0;
                    r_first <= 1'b1;
                    r_cnt   <= '0;
                    r_min   <= '1;
                    r_best  <= w_ident;
                end
                ST_CAL: begin
                    if (r_w == W_LAST) begin
                        // End of permutation: score the full total.
                        r_w    <= '0;
                        r_acc  <= '0;
                        r_perm <= w_next_perm;
                        if (r_first || w_better) begin
                            r_min   <= w_total;
                            r_cnt   <= MCW'(1);
                            r_best  <= r_perm;
                            r_first <= 1'b0;
                        end else if ((w_total == r_min) && (r_cnt != '1)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_w   <= r_w + 1'b1;
                        r_acc <= w_total;
                    end
                end
                default: ;
            endcase
        end
    end

    assign W          = r_w;
    assign J          = r_perm[IW*r_w +: IW];
    assign Busy       = r_busy;
    assign Valid      = r_valid;
    assign MinCost    = r_min;
    assign MatchCount = r_cnt;
    assign BestPerm   = r_best;

endmodule
`default_nettype wire

// File: tb/tb_jam_solver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jam_solver
//  Description : Self-checking bench for jam_solver. Two instances (N=3 and
//                N=4 with a 4-bit saturating match counter) share one cost
//                table; expected results come from a brute-force model that
//                enumerates all N^N tuples in lexicographic order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jam_solver;

    typedef struct {
        int mn;
        int cnt;
        int best;
        int lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic       sel;
    logic [6:0] cm [0:7][0:7];

    logic       start3, start4;
    logic [1:0] w3, j3, w4, j4;
    logic [6:0] cost3, cost4;
    logic       busy3, valid3, busy4, valid4;
    logic [8:0] min3, min4;
    logic [15:0] cnt3;
    logic [3:0] cnt4;
    logic [5:0] best3;
    logic [7:0] best4;

    int   s_valid, s_busy, s_min, s_cnt, s_best, s_w, s_j;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    assign start3 = start & ~sel;
    assign start4 = start & sel;
    assign cost3  = cm[w3][j3];
    assign cost4  = cm[w4][j4];

    jam_solver #(.N(3), .CW(7), .MCW(16)) u_dut3 (
        .CLK(clk), .RST(rst), .Start(start3), .Mode(mode),
        .W(w3), .J(j3), .Cost(cost3), .Busy(busy3), .Valid(valid3),
        .MinCost(min3), .MatchCount(cnt3), .BestPerm(best3)
    );

    jam_solver #(.N(4), .CW(7), .MCW(4)) u_dut4 (
        .CLK(clk), .RST(rst), .Start(start4), .Mode(mode),
        .W(w4), .J(j4), .Cost(cost4), .Busy(busy4), .Valid(valid4),
        .MinCost(min4), .MatchCount(cnt4), .BestPerm(best4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the selected instance; BestPerm re-encoded as 4 bits per worker.
    always_comb begin
        s_best = 0;
        if (!sel) begin
            s_valid = int'(valid3);
            s_busy  = int'(busy3);
            s_min   = int'(min3);
            s_cnt   = int'(cnt3);
            s_w     = int'(w3);
            s_j     = int'(j3);
            for (int w = 0; w < 3; w++) s_best = s_best | (int'(best3[2*w +: 2]) << (4*w));
        end else begin
            s_valid = int'(valid4);
            s_busy  = int'(busy4);
            s_min   = int'(min4);
            s_cnt   = int'(cnt4);
            s_w     = int'(w4);
            s_j     = int'(j4);
            for (int w = 0; w < 4; w++) s_best = s_best | (int'(best4[2*w +: 2]) << (4*w));
        end
    end

    task automatic check_value(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int fact(input int n);
        int f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    task automatic push_exp(input int mn, input int cnt, input int best, input int lat);
        exp_t e;
        e.mn = mn; e.cnt = cnt; e.best = best; e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Brute force over every N^N tuple; counting order is lexicographic,
    // so the first strict improvement found is the lexicographic first optimum.
    task automatic model_push(input int n, input int mode_v, input int satmax);
        int  d [8];
        int  t, used, total, best, cnt, bcode;
        bit  ok, first;
        first = 1'b1; best = 0; cnt = 0; bcode = 0;
        for (int code = 0; code < n**n; code++) begin
            t = code;
            for (int w = n-1; w >= 0; w--) begin
                d[w] = t % n;
                t    = t / n;
            end
            used = 0; ok = 1'b1; total = 0;
            for (int w = 0; w < n; w++) begin
                if (((used >> d[w]) & 1) != 0) ok = 1'b0;
                used  = used | (1 << d[w]);
                total = total + int'(cm[w][d[w]]);
            end
            if (ok) begin
                if (first || (mode_v != 0 ? total > best : total < best)) begin
                    first = 1'b0; best = total; cnt = 1; bcode = 0;
                    for (int w = 0; w < n; w++) bcode = bcode | (d[w] << (4*w));
                end else if (total == best && cnt < satmax) begin
                    cnt++;
                end
            end
        end
        push_exp(best, cnt, bcode, fact(n)*(n+1)+1);
    endtask

    task automatic set_costs(input int kind);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                case (kind)
                    0: cm[w][j] = 7'd0;
                    1: cm[w][j] = 7'd1;
                    2: cm[w][j] = (w == j) ? 7'd0 : 7'd5;
                    default: cm[w][j] = 7'($urandom_range(0, 3));
                endcase
    endtask

    task automatic check_reset(input int ident);
        check_value("rst_W",     s_w,     0);
        check_value("rst_J",     s_j,     0);
        check_value("rst_Busy",  s_busy,  0);
        check_value("rst_Valid", s_valid, 0);
        check_value("rst_Min",   s_min,   511);
        check_value("rst_Count", s_cnt,   0);
        check_value("rst_Best",  s_best,  ident);
    endtask

    // One run on the selected instance, compared against the oldest entry.
    task automatic run(input int mode_v, input int glitch);
        exp_t e;
        int   k;
        e = sb_q[0];
        k = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = mode_v[0];
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                check_value("load_Valid", s_valid, 0);
                check_value("load_Busy",  s_busy,  1);
            end
            if (glitch != 0 && k == 6) begin
                start = 1'b1;
                mode  = ~mode_v[0];
            end
            if (glitch != 0 && k == 7) begin
                start = 1'b0;
                mode  = mode_v[0];
            end
        end while (s_valid == 0 && k < e.lat + 50);
        e = sb_q.pop_front();
        check_value("latency",    k,      e.lat);
        check_value("MinCost",    s_min,  e.mn);
        check_value("MatchCount", s_cnt,  e.cnt);
        check_value("BestPerm",   s_best, e.best);
        check_value("done_Busy",  s_busy, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        sel   = 1'b0;
        set_costs(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset(12'h210);
        sel = 1'b1;
        #1;
        check_reset(16'h3210);
        rst = 1'b0;
        sel = 1'b0;
        #1;

        // N=3 all ones
        set_costs(1);
        push_exp(3, 6, 12'h210, 25);
        run(0, 0);

        // N=3 diagonal zero, other costs 5
        set_costs(2);
        push_exp(0, 1, 12'h210, 25);
        run(0, 0);
        push_exp(15, 2, 12'h021, 25);
        run(1, 0);
        push_exp(15, 2, 12'h021, 25);
        run(1, 0);

        // Start and Mode toggled mid-run must be ignored
        push_exp(0, 1, 12'h210, 25);
        run(0, 1);

        // N=3 random costs
        for (int i = 0; i < 4; i++) begin
            set_costs(3);
            model_push(3, i % 2, 65535);
            run(i % 2, 0);
        end

        // Reset mid-CAL, then a clean run
        set_costs(3);
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset(12'h210);
        rst = 1'b0;
        model_push(3, 0, 65535);
        run(0, 0);

        // N=4 with a 4-bit counter
        sel = 1'b1;
        #1;
        set_costs(0);
        push_exp(0, 15, 16'h3210, 121);
        run(0, 0);
        for (int i = 0; i < 4; i++) begin
            set_costs(3);
            model_push(4, i % 2, 15);
            run(i % 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
